// File: rtl/fb_pkg.sv
// Shared frame-buffer and VGA 640x480 timing constants for the scan-out block.
// Geometry is 160x120 stored pixels, each shown as a 4x4 block.
package fb_pkg;
  localparam logic [7:0]  FB_W     = 8'd160;
  localparam logic [6:0]  FB_H     = 7'd120;
  localparam logic [14:0] FB_DEPTH = 15'd19200;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_TOT  = 10'd800;
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_TOT  = 10'd525;

  typedef logic [2:0] colour_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fb_state_t;

  // row*160 + col as row*128 + row*32 + col, so no multiplier is inferred
  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return 15'({row, 7'b0000000}) + 15'({row, 5'b00000}) + 15'(col);
  endfunction
endpackage

// File: rtl/fb_scanout_vga_timing.sv
// Pixel-rate divider and 800x525 raster counters with raw (undelayed) sync,
// blanking and the one-clk pixel strobe.
module vga_timing
  import fb_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       visible,
  output logic       hs_n,
  output logic       vs_n
);
  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
  localparam logic [9:0] HS_START = H_VIS + H_FP;
  localparam logic [9:0] HS_END   = H_VIS + H_FP + H_SYNC;
  localparam logic [9:0] VS_START = V_VIS + V_FP;
  localparam logic [9:0] VS_END   = V_VIS + V_FP + V_SYNC;

  logic [1:0] div_r;
  logic [9:0] hcnt_r;
  logic [9:0] vcnt_r;

  assign pix_en = (div_r == DIV_LAST);
  assign hcnt   = hcnt_r;
  assign vcnt   = vcnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= 2'd0;
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else if (pix_en) begin
      div_r <= 2'd0;
      if (hcnt_r == H_TOT - 10'd1) begin
        hcnt_r <= 10'd0;
        vcnt_r <= (vcnt_r == V_TOT - 10'd1) ? 10'd0 : vcnt_r + 10'd1;
      end else begin
        hcnt_r <= hcnt_r + 10'd1;
      end
    end else begin
      div_r <= div_r + 2'd1;
    end
  end

  always_comb begin
    visible = (hcnt_r < H_VIS) && (vcnt_r < V_VIS);
    hs_n    = !((hcnt_r >= HS_START) && (hcnt_r < HS_END));
    vs_n    = !((vcnt_r >= VS_START) && (vcnt_r < VS_END));
  end
endmodule

// File: rtl/fb_scanout.sv
// 160x120x3 frame buffer with plot port, hardware clear engine and a
// 640x480 VGA scan-out that replicates each stored pixel as a 4x4 block.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int      PIX_DIV   = 2,
  parameter colour_t BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_pix_en
);
  logic       pix_en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       visible, hs_n, vs_n;

  vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .visible(visible),
    .hs_n   (hs_n),
    .vs_n   (vs_n)
  );

  fb_state_t   state_r, state_s;
  logic [14:0] clr_addr_r, clr_addr_s;
  logic        we_s;
  logic [14:0] wa_s;
  colour_t     wd_s;

  colour_t     mem [0:FB_DEPTH-15'd1];
  logic [14:0] addr_r;
  colour_t     rd_r;
  logic        vis0_r, hs0_r, vs0_r;
  logic        vis1_r, hs1_r, vs1_r;

  assign busy = (state_r == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= 15'd0;
    end else begin
      state_r    <= state_s;
      clr_addr_r <= clr_addr_s;
    end
  end

  // clear_req overrides everything, including a plot on the same edge
  always_comb begin
    state_s    = state_r;
    clr_addr_s = clr_addr_r;
    we_s       = 1'b0;
    wa_s       = 15'd0;
    wd_s       = BG_COLOUR;
    if (clear_req) begin
      state_s    = ST_CLEAR;
      clr_addr_s = 15'd0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          we_s = 1'b1;
          wa_s = clr_addr_r;
          if (clr_addr_r == FB_DEPTH - 15'd1) begin
            state_s = ST_RUN;
          end else begin
            clr_addr_s = clr_addr_r + 15'd1;
          end
        end
        ST_RUN: begin
          if (plot && (x < FB_W) && (y < FB_H)) begin
            we_s = 1'b1;
            wa_s = fb_addr(y, x);
            wd_s = colour;
          end else begin
            we_s = 1'b0;
          end
        end
        default: begin
          state_s    = ST_CLEAR;
          clr_addr_s = 15'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wa_s] <= wd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      rd_r <= mem[addr_r];
    end
  end

  // address, RAM data and output registers form a three-register chain;
  // the sync/visible flags ride an equal-length chain so all outputs align
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r      <= 15'd0;
      vis0_r      <= 1'b0;
      hs0_r       <= 1'b1;
      vs0_r       <= 1'b1;
      vis1_r      <= 1'b0;
      hs1_r       <= 1'b1;
      vs1_r       <= 1'b1;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_pix_en  <= 1'b0;
    end else begin
      vga_pix_en <= pix_en;
      if (pix_en) begin
        addr_r      <= visible ? fb_addr(7'(vcnt >> 2), 8'(hcnt >> 2)) : 15'd0;
        vis0_r      <= visible;
        hs0_r       <= hs_n;
        vs0_r       <= vs_n;
        vis1_r      <= vis0_r;
        hs1_r       <= hs0_r;
        vs1_r       <= vs0_r;
        vga_r       <= (vis1_r && rd_r[2]) ? 8'hFF : 8'h00;
        vga_g       <= (vis1_r && rd_r[1]) ? 8'hFF : 8'h00;
        vga_b       <= (vis1_r && rd_r[0]) ? 8'hFF : 8'h00;
        vga_hs      <= hs1_r;
        vga_vs      <= vs1_r;
        vga_blank_n <= vis1_r;
      end
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: reset, clear sweep, line timing, plotting
// with range rejection, clear_req during scan-out. Pixels are located from
// the blanking output itself, independent of pipeline latency.
module tb_fb_scanout;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic [2:0] colour = 3'd0;
  logic       plot = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_pix_en;

  int total = 0;
  int bad = 0;

  logic [2:0]  model [0:19199];
  logic [24:0] obs [0:63][0:639];
  int          trk_row = 0;
  int          trk_col = 0;
  logic        prev_blank = 1'b0;

  fb_scanout dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .colour(colour), .plot(plot),
    .clear_req(clear_req), .busy(busy), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_pix_en(vga_pix_en)
  );

  always #5 clk = ~clk;

  // records every displayed visible pixel by (line, column) since reset
  always @(negedge clk) begin
    if (rst) begin
      trk_row    <= 0;
      trk_col    <= 0;
      prev_blank <= 1'b0;
    end else if (vga_pix_en) begin
      if (vga_blank_n) begin
        if (trk_row < 64 && trk_col < 640)
          obs[trk_row][trk_col] <= {1'b1, vga_r, vga_g, vga_b};
        trk_col <= trk_col + 1;
      end else if (prev_blank) begin
        trk_row <= trk_row + 1;
        trk_col <= 0;
      end
      prev_blank <= vga_blank_n;
    end
  end

  function automatic logic [24:0] exp_px(input int row, input int col);
    logic [2:0] c;
    c = model[(row / 4) * 160 + (col / 4)];
    return {1'b1, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic do_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    @(negedge clk);
    x = px; y = py; colour = pc; plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
  endtask

  task automatic check_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      for (int c = 0; c < 640; c++) begin
        total++;
        if (obs[r][c] !== exp_px(r, c)) begin
          bad++;
          $display("FAIL pixel r=%0d c=%0d got=%h want=%h", r, c, obs[r][c], exp_px(r, c));
        end
      end
    end
  endtask

  task automatic wait_row(input int row);
    int n = 0;
    while (trk_row < row && n < 40000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (trk_row < row) begin
      bad++;
      $display("FAIL wait_row got=%0d want=%0d", trk_row, row);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 6;
    if (busy !== 1'b1)        begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
    if (vga_hs !== 1'b1)      begin bad++; $display("FAIL rst_hs got=%b want=1", vga_hs); end
    if (vga_vs !== 1'b1)      begin bad++; $display("FAIL rst_vs got=%b want=1", vga_vs); end
    if (vga_blank_n !== 1'b0) begin bad++; $display("FAIL rst_blank got=%b want=0", vga_blank_n); end
    if (vga_pix_en !== 1'b0)  begin bad++; $display("FAIL rst_pix_en got=%b want=0", vga_pix_en); end
    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
      bad++; $display("FAIL rst_rgb got=%h want=000000", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    rst = 1'b0;
    while (vga_hs !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total += 2;
    if (vga_hs !== 1'b0) begin bad++; $display("FAIL mid_hs_seen got=%b want=0", vga_hs); end
    if (busy !== 1'b1)   begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (vga_hs !== 1'b1)      begin bad++; $display("FAIL async_hs got=%b want=1", vga_hs); end
    if (vga_vs !== 1'b1)      begin bad++; $display("FAIL async_vs got=%b want=1", vga_vs); end
    if (vga_blank_n !== 1'b0) begin bad++; $display("FAIL async_blank got=%b want=0", vga_blank_n); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear_sweep();
    int cnt = 0;
    int nonzero = 0;
    rst = 1'b0;
    while (busy === 1'b1 && cnt < 25000) begin
      if ({vga_r, vga_g, vga_b} !== 24'h000000) nonzero++;
      cnt++;
      @(negedge clk);
    end
    for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    total += 3;
    if (cnt !== 19200)  begin bad++; $display("FAIL clear_len got=%0d want=19200", cnt); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL clear_done got=%b want=0", busy); end
    if (nonzero !== 0)  begin bad++; $display("FAIL clear_rgb got=%0d want=0", nonzero); end
  endtask

  task automatic test_line_timing();
    int n = 0;
    int period = 0;
    int hs_low = 0;
    int blank_hi = 0;
    int vs_low = 0;
    int held_bad = 0;
    logic prev_hs;
    logic [26:0] prev_out;
    prev_hs = vga_hs;
    do begin
      prev_hs = vga_hs;
      @(negedge clk);
      n++;
    end while (!(prev_hs && !vga_hs) && n < 4000);
    prev_out = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n};
    do begin
      if (!vga_hs) hs_low++;
      if (vga_blank_n) blank_hi++;
      if (!vga_vs) vs_low++;
      period++;
      prev_hs = vga_hs;
      @(negedge clk);
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== prev_out && !vga_pix_en)
        held_bad++;
      prev_out = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n};
    end while (!(prev_hs && !vga_hs) && period < 4000);
    total += 5;
    if (period !== 1600)  begin bad++; $display("FAIL line_period got=%0d want=1600", period); end
    if (hs_low !== 192)   begin bad++; $display("FAIL hs_width got=%0d want=192", hs_low); end
    if (blank_hi !== 1280) begin bad++; $display("FAIL blank_width got=%0d want=1280", blank_hi); end
    if (vs_low !== 0)     begin bad++; $display("FAIL vs_early got=%0d want=0", vs_low); end
    if (held_bad !== 0)   begin bad++; $display("FAIL hold got=%0d want=0", held_bad); end
  endtask

  task automatic test_plot();
    do_plot(8'd5, 7'd6, 3'b110);   model[6 * 160 + 5] = 3'b110;
    do_plot(8'd6, 7'd7, 3'b011);   model[7 * 160 + 6] = 3'b011;
    do_plot(8'd159, 7'd7, 3'b001); model[7 * 160 + 159] = 3'b001;
    do_plot(8'd160, 7'd6, 3'b111);
    do_plot(8'd255, 7'd6, 3'b101);
    do_plot(8'd0, 7'd120, 3'b111);
    do_plot(8'd0, 7'd127, 3'b111);
    wait_row(32);
    check_rows(24, 31);
  endtask

  task automatic test_clear_req();
    int cnt = 0;
    int f1 = -1;
    int f2 = -1;
    logic prev_hs;
    @(negedge clk);
    clear_req = 1'b1; plot = 1'b1; x = 8'd20; y = 7'd11; colour = 3'b111;
    @(negedge clk);
    clear_req = 1'b0; plot = 1'b0;
    for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    prev_hs = vga_hs;
    while (busy === 1'b1 && cnt < 25000) begin
      if (cnt == 100) begin plot = 1'b1; x = 8'd10; y = 7'd11; colour = 3'b101; end
      if (cnt == 101) plot = 1'b0;
      if (prev_hs && !vga_hs) begin
        if (f1 < 0) f1 = cnt;
        else if (f2 < 0) f2 = cnt;
      end
      prev_hs = vga_hs;
      cnt++;
      @(negedge clk);
    end
    total += 2;
    if (cnt !== 19200)     begin bad++; $display("FAIL reclear_len got=%0d want=19200", cnt); end
    if (f2 - f1 !== 1600)  begin bad++; $display("FAIL reclear_period got=%0d want=1600", f2 - f1); end
    wait_row(48);
    check_rows(44, 47);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_reset_mid_clear();
    test_clear_sweep();
    test_line_timing();
    test_plot();
    test_clear_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Receiving end of the pixel-plot interface that the title, game-over and flash drawers drive with x, y, colour and plot.
- Stores plotted pixels in a 160x120, 3-bit frame buffer.
- Continuously scans the buffer out as 640x480 VGA, replicating each stored pixel as a 4x4 block.
- Sits between the draw/control logic and the board's VGA DAC pins; includes a hardware clear engine.

Parameters:
- PIX_DIV, 2, clk cycles per VGA pixel (50 MHz clk -> 25 MHz pixel rate); legal values 1..4.
- BG_COLOUR, 3'b000, colour written by the clear engine.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- x  in  8  plot column, 0..159.
- y  in  7  plot row, 0..119.
- colour  in  3  {R,G,B} plot colour.
- plot  in  1  write strobe, one pixel per clk cycle while high.
- clear_req  in  1  one-cycle pulse; starts a full-buffer clear.
- busy  out  1  high while the clear engine runs.
- vga_r, vga_g, vga_b  out  8 each  channel = 8'hFF if the colour bit is set, else 8'h00.
- vga_hs, vga_vs  out  1  active-low sync.
- vga_blank_n  out  1  high in the visible region.
- vga_pix_en  out  1  one-clk strobe per VGA pixel.

Behaviour:
- Reset (async assert, sync release):
  - hcnt=0, vcnt=0, divider=0.
  - FSM=CLEAR, clr_addr=0.
  - Outputs: rgb=0, vga_hs=1, vga_vs=1, vga_blank_n=0, busy=1, vga_pix_en=0.
  - Reset does not touch RAM contents; the clear engine handles them.
- Frame buffer:
  - 19200 x 3 inferred simple dual-port RAM; write address = y*160+x.
  - Read latency is 1 clk; read-during-write to the same address returns old data.
- FSM CLEAR:
  - Each clk, write BG_COLOUR at clr_addr, then clr_addr+1.
  - At clr_addr==19199, write and go to RUN on the next edge.
  - Clear takes exactly 19200 clks; busy deasserts on the cycle RUN is entered.
  - plot is ignored while in CLEAR.
- FSM RUN:
  - plot=1 with x<160 and y<120 writes colour that edge.
  - Out-of-range coordinates are silently dropped (no wrap, no alias).
  - clear_req returns the FSM to CLEAR with clr_addr=0.
  - clear_req arriving while already in CLEAR restarts the sweep at 0.
  - clear_req and plot on the same edge: the clear wins and the plot is dropped.
- Scan counters (advance only when the divider reaches PIX_DIV-1; vga_pix_en is high that cycle):
  - hcnt counts 0..799 and wraps to 0, incrementing vcnt.
  - vcnt counts 0..524 and wraps to 0.
- Timing (pre-pipeline):
  - visible = hcnt<640 && vcnt<480.
  - hs_n = !(656<=hcnt<=751).
  - vs_n = !(490<=vcnt<=491).
- Read address = (vcnt>>2)*160 + (hcnt>>2), computed with a shift-add; no multiplier or divider.
- Scanning continues during CLEAR; the display shows the partially cleared buffer.
- Pipeline, in pix_en ticks:
  - Stage 0: counters -> address register.
  - Stage 1: RAM read.
  - Stage 2: output registers.
  - hs/vs/visible are delayed by the same 2 ticks, so rgb, sync and blank are mutually aligned.
  - rgb is forced to 0 whenever the delayed visible is 0.
- Outputs change only on cycles where vga_pix_en=1; they hold otherwise.

Decomposition:
- Package fb_pkg holds:
  - FB_W=160, FB_H=120, FB_DEPTH=19200.
  - H_VIS=640, H_FP=16, H_SYNC=96, H_TOT=800.
  - V_VIS=480, V_FP=10, V_SYNC=2, V_TOT=525.
  - colour_t (3-bit).
- One sub-module, vga_timing: divider, h/v counters, raw hs/vs/visible and pix_en.
- The RAM, clear FSM and output pipeline stay in fb_scanout.

Test Plan:
1. Release reset; count cycles -> busy high for exactly 19200 clks, then low; every scanned visible pixel reads rgb=0.
2. After the clear, plot (x=5, y=3, colour=3'b110) -> when hcnt=20..23 and vcnt=12..15 reach stage 2: vga_r=FF, vga_g=FF, vga_b=00. Neighbouring pixels stay 0.
3. Plot x=160,y=0 and x=0,y=120 with colour 3'b111 -> no write. Addresses 0 and 119*160 stay 0, with no alias at address 19200 or wrap.
4. Measure one line with PIX_DIV=2 -> 1600 clks per line; vga_hs low for 192 clks; vga_blank_n high for 1280 clks. vga_vs low for 2 lines per 525.
5. clear_req mid-frame while scanning previously plotted data -> busy=1; the 19200-clk sweep repeats; a plot during busy has no effect. The sync cadence is unchanged.
6. Assert rst 500 clks into the clear, then release -> the sweep restarts at clr_addr=0 and busy stays high a full 19200 clks. vga_hs=1 and vga_vs=1 immediately on assertion, without waiting for a clock edge.
